// File: rtl/t05_sram_arb.sv
// Shared single-port word memory with round-robin arbitration across NCLIENT clients.
// Each client addresses a private region of the array. A bulk-clear sweep zeroes every word.
module t05_sram_arb #(
   parameter  int NCLIENT   = 5,
   parameter  int DATA_W    = 32,
   parameter  int REGION_AW = 8,
   localparam int DEPTH     = NCLIENT * (2 ** REGION_AW)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NCLIENT-1:0]            req,
   input  logic [NCLIENT-1:0]            we,
   input  logic [NCLIENT*REGION_AW-1:0]  addr,
   input  logic [NCLIENT*DATA_W-1:0]     wdata,
   input  logic                          clr_req,
   output logic [NCLIENT-1:0]            gnt,
   output logic [NCLIENT-1:0]            rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy,
   output logic                          clr_done
);
   localparam int CW  = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
   localparam int PAW = $clog2(DEPTH);

   typedef enum logic {SERVE, CLR} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       ptr_q, ptr_d;
   logic [PAW-1:0]      cnt_q, cnt_d;
   logic [NCLIENT-1:0]  rvalid_q, rvalid_d;
   logic                busy_q, busy_d;
   logic                clr_done_q, clr_done_d;
   logic [DATA_W-1:0]   rdata_q;

   logic [REGION_AW-1:0] addr_a  [NCLIENT];
   logic [DATA_W-1:0]    wdata_a [NCLIENT];

   logic [NCLIENT-1:0]  gnt_c;
   logic [CW-1:0]       gnt_idx;
   logic                gnt_any;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we, mem_rd;
   logic [PAW-1:0]      mem_addr;
   logic [DATA_W-1:0]   mem_wdata;

   for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_unpack
      assign addr_a[gi]  = addr[gi*REGION_AW +: REGION_AW];
      assign wdata_a[gi] = wdata[gi*DATA_W +: DATA_W];
   end

   // Scan from the round-robin pointer; the first requester found wins.
   always_comb begin
      logic [CW-1:0] cand;
      gnt_c   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      if (state_q == SERVE) begin
         for (int i = 0; i < NCLIENT; i++) begin
            cand = CW'((int'(ptr_q) + i) % NCLIENT);
            if (!gnt_any && req[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
         if (gnt_any) gnt_c[gnt_idx] = 1'b1;
      end
   end

   // The clear sweep owns the single port while in CLR; otherwise the granted client does.
   always_comb begin
      mem_we    = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = PAW'({gnt_idx, addr_a[gnt_idx]});
      mem_wdata = wdata_a[gnt_idx];
      if (state_q == CLR) begin
         mem_we    = 1'b1;
         mem_addr  = cnt_q;
         mem_wdata = '0;
      end else if (gnt_any) begin
         mem_we = we[gnt_idx];
         mem_rd = !we[gnt_idx];
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      rvalid_d   = '0;
      clr_done_d = 1'b0;
      case (state_q)
         SERVE: begin
            if (gnt_any) begin
               ptr_d = (gnt_idx == CW'(NCLIENT - 1)) ? '0 : CW'(gnt_idx + 1'b1);
               if (!we[gnt_idx]) rvalid_d = gnt_c;
            end
            if (clr_req) begin
               state_d = CLR;
               cnt_d   = '0;
            end
         end
         CLR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PAW'(DEPTH - 1)) begin
               cnt_d      = '0;
               state_d    = SERVE;
               clr_done_d = 1'b1;
            end
         end
         default: state_d = SERVE;
      endcase
      busy_d = (state_d == CLR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= SERVE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         rvalid_q   <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         rvalid_q   <= rvalid_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
      end
   end

   // Array writes are suppressed during reset so an aborted clear leaves the current word intact.
   always_ff @(posedge clk) begin
      if (mem_we && rst) mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) rdata_q <= '0;
      else if (mem_rd) rdata_q <= mem[mem_addr];
   end

   assign gnt      = gnt_c;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign busy     = busy_q;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_t05_sram_arb.sv
// Directed bench for t05_sram_arb: arbitration order, region mapping, read latency,
// bulk clear, clear coinciding with a read grant, and reset aborting a clear.
module tb_t05_sram_arb;
   localparam int NC = 5;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int DEPTH = NC * (2 ** AW);

   logic             clk;
   logic             rst;
   logic [NC-1:0]    req;
   logic [NC-1:0]    we;
   logic [NC*AW-1:0] addr;
   logic [NC*DW-1:0] wdata;
   logic             clr_req;
   logic [NC-1:0]    gnt;
   logic [NC-1:0]    rvalid;
   logic [DW-1:0]    rdata;
   logic             busy;
   logic             clr_done;

   int n_checks;
   int n_fail;

   t05_sram_arb #(.NCLIENT(NC), .DATA_W(DW), .REGION_AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .clr_req  (clr_req),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .busy     (busy),
      .clr_done (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-client access: drive at a negedge, sample gnt before the edge,
   // then sample rvalid/rdata at the following negedge.
   task automatic do_access(input int c, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output logic [NC-1:0] g,
                            output logic [NC-1:0] rv, output logic [DW-1:0] rd);
      @(negedge clk);
      req = '0;
      we  = '0;
      req[c] = 1'b1;
      we[c]  = w;
      addr[c*AW +: AW]  = a;
      wdata[c*DW +: DW] = d;
      #1 g = gnt;
      @(negedge clk);
      rv  = rvalid;
      rd  = rdata;
      req = '0;
      $display("txn client %0d %s local 0x%h wdata 0x%h gnt %b rvalid %b rdata 0x%h",
               c, w ? "WR" : "RD", a, d, g, rv, rd);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      clr_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (rvalid !== 5'b00000) begin n_fail++; $display("FAIL reset_rvalid: got %b exp %b", rvalid, 5'b00000); end
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp %h", rdata, 32'h0); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done: got %b exp 0", clr_done); end
      n_checks++;
      if (gnt !== 5'b00000) begin n_fail++; $display("FAIL reset_gnt_idle: got %b exp %b", gnt, 5'b00000); end
      @(negedge clk);
      rst = 1'b1;
      req = '1;
      #1;
      n_checks++;
      if (gnt !== 5'b00001) begin n_fail++; $display("FAIL reset_ptr0: got %b exp %b", gnt, 5'b00001); end
      req = '0;
      $display("txn reset released, all-request probe gnt %b", gnt);
   endtask

   task automatic test_write_read();
      logic [NC-1:0] g, rv;
      logic [DW-1:0] rd;
      do_access(0, 1'b1, 8'h05, 32'hDEADBEEF, g, rv, rd);
      n_checks++;
      if (g !== 5'b00001) begin n_fail++; $display("FAIL wr0_gnt: got %b exp %b", g, 5'b00001); end
      n_checks++;
      if (rv !== 5'b00000) begin n_fail++; $display("FAIL wr0_rvalid: got %b exp %b", rv, 5'b00000); end
      do_access(0, 1'b0, 8'h05, 32'h0, g, rv, rd);
      n_checks++;
      if (g !== 5'b00001) begin n_fail++; $display("FAIL rd0_gnt: got %b exp %b", g, 5'b00001); end
      n_checks++;
      if (rv !== 5'b00001) begin n_fail++; $display("FAIL rd0_rvalid: got %b exp %b", rv, 5'b00001); end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd0_rdata: got %h exp %h", rd, 32'hDEADBEEF); end
      @(negedge clk);
      n_checks++;
      if (rvalid !== 5'b00000) begin n_fail++; $display("FAIL rd0_rvalid_pulse: got %b exp %b", rvalid, 5'b00000); end
      n_checks++;
      if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd0_rdata_hold: got %h exp %h", rdata, 32'hDEADBEEF); end
   endtask

   task automatic test_regions();
      logic [NC-1:0] g, rv;
      logic [DW-1:0] rd;
      do_access(1, 1'b1, 8'h00, 32'h11111111, g, rv, rd);
      do_access(3, 1'b1, 8'h00, 32'h33333333, g, rv, rd);
      do_access(1, 1'b0, 8'h00, 32'h0, g, rv, rd);
      n_checks++;
      if (g !== 5'b00010) begin n_fail++; $display("FAIL reg1_gnt: got %b exp %b", g, 5'b00010); end
      n_checks++;
      if (rv !== 5'b00010) begin n_fail++; $display("FAIL reg1_rvalid: got %b exp %b", rv, 5'b00010); end
      n_checks++;
      if (rd !== 32'h11111111) begin n_fail++; $display("FAIL reg1_rdata: got %h exp %h", rd, 32'h11111111); end
      do_access(3, 1'b0, 8'h00, 32'h0, g, rv, rd);
      n_checks++;
      if (g !== 5'b01000) begin n_fail++; $display("FAIL reg3_gnt: got %b exp %b", g, 5'b01000); end
      n_checks++;
      if (rv !== 5'b01000) begin n_fail++; $display("FAIL reg3_rvalid: got %b exp %b", rv, 5'b01000); end
      n_checks++;
      if (rd !== 32'h33333333) begin n_fail++; $display("FAIL reg3_rdata: got %h exp %h", rd, 32'h33333333); end
   endtask

   task automatic test_round_robin();
      logic [DW-1:0] exp_rd [NC];
      logic          known  [NC];
      logic [NC-1:0] exp_g, exp_v;
      int            prev;
      exp_rd = '{32'hDEADBEEF, 32'h11111111, 32'h0, 32'h33333333, 32'h0};
      known  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      apply_reset();
      @(negedge clk);
      addr = '0;
      addr[0*AW +: AW] = 8'h05;
      we  = '0;
      req = '1;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp_g = '0;
         exp_g[i % NC] = 1'b1;
         n_checks++;
         if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b exp %b", i, gnt, exp_g); end
         if (i > 0) begin
            prev  = (i - 1) % NC;
            exp_v = '0;
            exp_v[prev] = 1'b1;
            n_checks++;
            if (rvalid !== exp_v) begin n_fail++; $display("FAIL rr_rvalid_%0d: got %b exp %b", i, rvalid, exp_v); end
            if (known[prev]) begin
               n_checks++;
               if (rdata !== exp_rd[prev]) begin n_fail++; $display("FAIL rr_rdata_%0d: got %h exp %h", i, rdata, exp_rd[prev]); end
            end
         end
         $display("txn rr cycle %0d gnt %b rvalid %b rdata 0x%h", i, gnt, rvalid, rdata);
         @(negedge clk);
      end
      req = '0;
      #1;
      n_checks++;
      if (rvalid !== 5'b00001) begin n_fail++; $display("FAIL rr_rvalid_last: got %b exp %b", rvalid, 5'b00001); end
      n_checks++;
      if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rr_rdata_last: got %h exp %h", rdata, 32'hDEADBEEF); end
      n_checks++;
      if (gnt !== 5'b00000) begin n_fail++; $display("FAIL rr_gnt_idle: got %b exp %b", gnt, 5'b00000); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req = 5'b10000;
      we  = 5'b10000;
      addr[4*AW +: AW]  = 8'h7F;
      wdata[4*DW +: DW] = 32'hB2B2B2B2;
      #1;
      n_checks++;
      if (gnt !== 5'b10000) begin n_fail++; $display("FAIL b2b_wr_gnt: got %b exp %b", gnt, 5'b10000); end
      @(negedge clk);
      we = '0;
      #1;
      n_checks++;
      if (gnt !== 5'b10000) begin n_fail++; $display("FAIL b2b_rd_gnt: got %b exp %b", gnt, 5'b10000); end
      n_checks++;
      if (rvalid !== 5'b00000) begin n_fail++; $display("FAIL b2b_wr_rvalid: got %b exp %b", rvalid, 5'b00000); end
      @(negedge clk);
      req = '0;
      n_checks++;
      if (rvalid !== 5'b10000) begin n_fail++; $display("FAIL b2b_rvalid: got %b exp %b", rvalid, 5'b10000); end
      n_checks++;
      if (rdata !== 32'hB2B2B2B2) begin n_fail++; $display("FAIL b2b_rdata: got %h exp %h", rdata, 32'hB2B2B2B2); end
      $display("txn b2b client 4 write/read local 0x7f rdata 0x%h", rdata);
   endtask

   task automatic test_clear();
      logic [NC-1:0] g, rv;
      logic [DW-1:0] rd;
      int busy_cnt, done_cnt, gnt_bad;
      logic got;
      do_access(2, 1'b1, 8'h10, 32'hA5A5A5A5, g, rv, rd);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      we  = '0;
      req = 5'b00100;
      addr[2*AW +: AW] = 8'h10;
      busy_cnt = 0;
      done_cnt = 0;
      gnt_bad  = 0;
      got      = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         #1;
         if (busy) begin
            busy_cnt++;
            if (gnt !== 5'b00000) gnt_bad++;
         end
         if (clr_done) done_cnt++;
         if (gnt === 5'b00100 && !busy) got = 1'b1;
         else @(negedge clk);
      end
      $display("txn clear busy_cycles %0d clr_done_pulses %0d", busy_cnt, done_cnt);
      n_checks++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL clr_stalled_grant: got %b exp 1", got); end
      n_checks++;
      if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d exp %0d", busy_cnt, DEPTH); end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL clr_done_count: got %0d exp 1", done_cnt); end
      n_checks++;
      if (gnt_bad != 0) begin n_fail++; $display("FAIL clr_gnt_blocked: got %0d grants exp 0", gnt_bad); end
      @(negedge clk);
      req = '0;
      n_checks++;
      if (rvalid !== 5'b00100) begin n_fail++; $display("FAIL clr_read_rvalid: got %b exp %b", rvalid, 5'b00100); end
      n_checks++;
      if (rdata !== 32'h0) begin n_fail++; $display("FAIL clr_read_rdata: got %h exp %h", rdata, 32'h0); end
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL clr_done_pulse: got %b exp 0", clr_done); end
      do_access(0, 1'b0, 8'h05, 32'h0, g, rv, rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL clr_word5_zero: got %h exp %h", rd, 32'h0); end
   endtask

   task automatic test_clear_with_read();
      logic [NC-1:0] g, rv;
      logic [DW-1:0] rd;
      logic done;
      do_access(2, 1'b1, 8'h20, 32'hC0FFEE02, g, rv, rd);
      @(negedge clk);
      req = 5'b00100;
      we  = '0;
      addr[2*AW +: AW] = 8'h20;
      clr_req = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 5'b00100) begin n_fail++; $display("FAIL cwr_gnt: got %b exp %b", gnt, 5'b00100); end
      @(negedge clk);
      req = '0;
      clr_req = 1'b0;
      n_checks++;
      if (rvalid !== 5'b00100) begin n_fail++; $display("FAIL cwr_rvalid: got %b exp %b", rvalid, 5'b00100); end
      n_checks++;
      if (rdata !== 32'hC0FFEE02) begin n_fail++; $display("FAIL cwr_rdata: got %h exp %h", rdata, 32'hC0FFEE02); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL cwr_busy: got %b exp 1", busy); end
      $display("txn clear+read client 2 rdata 0x%h busy %b", rdata, busy);
      done = 1'b0;
      for (int i = 0; i < DEPTH + 20 && !done; i++) begin
         @(negedge clk);
         if (clr_done) done = 1'b1;
      end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL cwr_clr_done: got %b exp 1", done); end
      do_access(2, 1'b0, 8'h20, 32'h0, g, rv, rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL cwr_word_cleared: got %h exp %h", rd, 32'h0); end
   endtask

   task automatic test_reset_mid_clear();
      logic [NC-1:0] g, rv;
      logic [DW-1:0] rd;
      int done_cnt;
      do_access(0, 1'b1, 8'd50,  32'h50505050, g, rv, rd);
      do_access(0, 1'b1, 8'd200, 32'h20020020, g, rv, rd);
      @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rmc_busy_start: got %b exp 1", busy); end
      repeat (99) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy_abort: got %b exp 0", busy); end
      n_checks++;
      if (clr_done !== 1'b0) begin n_fail++; $display("FAIL rmc_clr_done: got %b exp 0", clr_done); end
      done_cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         if (clr_done) done_cnt++;
      end
      n_checks++;
      if (done_cnt != 0) begin n_fail++; $display("FAIL rmc_no_done: got %0d pulses exp 0", done_cnt); end
      $display("txn reset mid-clear at cycle 100, later clr_done pulses %0d", done_cnt);
      do_access(0, 1'b0, 8'd50, 32'h0, g, rv, rd);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL rmc_word50: got %h exp %h", rd, 32'h0); end
      do_access(0, 1'b0, 8'd200, 32'h0, g, rv, rd);
      n_checks++;
      if (rd !== 32'h20020020) begin n_fail++; $display("FAIL rmc_word200: got %h exp %h", rd, 32'h20020020); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      req      = '0;
      we       = '0;
      addr     = '0;
      wdata    = '0;
      clr_req  = 1'b0;
      test_reset();
      test_write_read();
      test_regions();
      test_round_robin();
      test_back_to_back();
      test_clear();
      test_clear_with_read();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/t05_sram_arb.md
Name: t05_sram_arb

Overview:
- Parametrised, multi-client word memory for the compression datapath.
- Arbitrates between NCLIENT requesters, e.g. histogram, find-least, htree, codebook and translation, using round-robin priority.
- Maps each client's local address into a private fixed-size region of one shared single-port array.
- Supports read and write with a req/gnt/rvalid handshake, plus a bulk-clear mode that zeroes the whole array before a new pass.

Parameters:
- NCLIENT, 5, number of requesting clients; client index c owns region c.
- DATA_W, 32, word width in bits.
- REGION_AW, 8, local address width; each region holds 2^REGION_AW words.
- DEPTH, NCLIENT*2^REGION_AW, total words (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk).
- req  in  NCLIENT  per-client access request; held until granted.
- we  in  NCLIENT  per-client write enable (1 = write, 0 = read); valid while req.
- addr  in  NCLIENT*REGION_AW  packed local addresses; client c uses slice [c*REGION_AW +: REGION_AW].
- wdata  in  NCLIENT*DATA_W  packed write data; client c uses slice [c*DATA_W +: DATA_W].
- clr_req  in  1  pulse or level; requests a bulk clear of the entire array.
- gnt  out  NCLIENT  one-hot grant; the access executes on the same rising edge.
- rvalid  out  NCLIENT  one-hot; one-cycle pulse marking read data valid for client c.
- rdata  out  DATA_W  registered read data shared by all clients; qualify with rvalid.
- busy  out  1  high while clearing.
- clr_done  out  1  one-cycle pulse after the last word is cleared.

Behaviour:
- Reset (rst=0 at edge):
  - state=SERVE; rr pointer=0; rvalid=0; rdata=0; busy=0; clr_done=0; clear counter=0.
  - Array contents are not cleared by reset.
  - A reset mid-clear aborts the clear; memory is partially cleared and clr_done is not pulsed.
- States:
  - SERVE -> CLR when clr_req=1 at the edge.
  - CLR -> SERVE after the word DEPTH-1 is written.
- SERVE:
  - gnt is combinational from req and the rr pointer.
  - Search order is ptr, ptr+1, ..., wrapping modulo NCLIENT; the first asserted req wins.
  - At most one gnt bit is high per cycle. gnt=0 when no req, or when state≠SERVE.
  - On the edge where gnt[c]=1:
    - Physical address = c*2^REGION_AW + addr_c.
    - Write (we_c=1): mem[phys] <= wdata_c.
    - Read (we_c=0): rdata <= mem[phys], and rvalid[c] <= 1 on the following cycle. Read latency is 1 cycle after the grant edge.
    - ptr <= (c+1) mod NCLIENT.
  - With no grant, ptr holds.
- rdata holds its last value when rvalid=0.
- rvalid is cleared every cycle unless a read is granted that cycle.
- Write then read of the same physical word on consecutive grants returns the new data.
- Simultaneous clr_req and req at one edge:
  - The granted access executes first.
  - CLR is entered at that same edge and begins clearing next cycle.
  - A read issued on that edge still returns its rvalid.
- CLR:
  - busy=1; all gnt=0; requesting clients stall with req held.
  - Counter runs 0..DEPTH-1, one word per cycle; mem[cnt] <= 0.
  - On the cnt=DEPTH-1 edge: clr_done <= 1 for one cycle; busy <= 0; return to SERVE.
  - Total duration is DEPTH cycles.
  - clr_req during CLR is ignored; no restart.
- Clients must not change addr, wdata or we while req=1 and gnt=0.
- A client may drop req before it is granted; no access occurs.
- Back-to-back: a client holding req high after a grant re-competes next cycle. Round-robin guarantees service within NCLIENT grant cycles.

Test Plan:
- Reset, then client 0 writes 0xDEADBEEF at local 0x05, then reads 0x05 → gnt[0] on both requests; rvalid[0] one cycle after the read grant with rdata=0xDEADBEEF.
- Clients 1 and 3 each write 0x11111111 and 0x33333333 to local 0x00, then read back → each client gets its own value, proving regions are disjoint (phys 0x100 vs 0x300).
- All 5 clients hold req (reads) continuously from ptr=0 → grant order 0,1,2,3,4,0; exactly one gnt per cycle; rvalid follows its gnt by 1 cycle.
- Fill several words, pulse clr_req → busy=1 for 1280 cycles with gnt=0 while req is held; clr_done pulses once; the stalled read is then granted and returns 0.
- Pulse clr_req on the same edge as a read grant by client 2 → rvalid[2] with the pre-clear data, then CLR starts.
- Drive rst=0 for one edge at clear cycle 100 → busy=0, no clr_done; word 50 reads 0 and word 200 retains its prior value.
